// File: rtl/kv_lookup_responder_pkg.sv
// Shared definitions for the key/flag lookup interface: opcodes, result flag bits,
// default geometry and the responder's internal enums.
package kv_lookup_responder_pkg;

    localparam int KV_KEY_SIZE = 96;
    localparam int KV_IDX_W    = 10;
    localparam int KV_OP_W     = 4;

    localparam logic [3:0] KV_OP_LOOKUP = 4'h1;
    localparam logic [3:0] KV_OP_INSERT = 4'h2;
    localparam logic [3:0] KV_OP_DELETE = 4'h4;

    localparam logic [3:0] KV_FLAG_HIT     = 4'h1;
    localparam logic [3:0] KV_FLAG_WRITTEN = 4'h2;
    localparam logic [3:0] KV_FLAG_REMOVED = 4'h4;
    localparam logic [3:0] KV_FLAG_ERR     = 4'h8;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } fsm_state_t;

    // OPC_REJECT covers both illegal opcodes and requests that arrive while clearing.
    typedef enum logic [1:0] {
        OPC_LOOKUP,
        OPC_INSERT,
        OPC_DELETE,
        OPC_REJECT
    } op_kind_t;

    function automatic op_kind_t decode_op(input logic [3:0] flag);
        case (flag)
            KV_OP_LOOKUP: return OPC_LOOKUP;
            KV_OP_INSERT: return OPC_INSERT;
            KV_OP_DELETE: return OPC_DELETE;
            default:      return OPC_REJECT;
        endcase
    endfunction

endpackage

// File: rtl/kv_lookup_responder_if.sv
// Request/response bundle between eth_encap (master) and the lookup responder (slave).
interface kv_lookup_responder_if
    import kv_lookup_responder_pkg::*;
#(
    parameter int KEY_SIZE = KV_KEY_SIZE,
    parameter int OP_W     = KV_OP_W
);
    logic                in_valid;
    logic [KEY_SIZE-1:0] in_key;
    logic [OP_W-1:0]     in_flag;
    logic                out_valid;
    logic [OP_W-1:0]     out_flag;
    logic                init_done;

    modport master (
        output in_valid, in_key, in_flag,
        input  out_valid, out_flag, init_done
    );

    modport slave (
        input  in_valid, in_key, in_flag,
        output out_valid, out_flag, init_done
    );
endinterface

// File: rtl/kv_table_ram.sv
// Simple dual-port 1R1W table RAM, read-first with a registered read port, BRAM-inferable.
module kv_table_ram #(
    parameter int WIDTH  = 97,
    parameter int ADDR_W = 10
) (
    input  logic              clk156,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);
    // NOTE: no reset on the array; a reset would stop BRAM inference, and the INIT sweep clears it instead.
    logic [WIDTH-1:0] mem [2**ADDR_W];

    // NOTE: non-blocking here is what makes a same-address read return the pre-write (old) word.
    always_ff @(posedge clk156) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/kv_lookup_responder.sv
// Direct-mapped key table responder: hash, 3-stage lookup pipeline with write forwarding,
// and the INIT sweep that clears every entry after reset.
module kv_lookup_responder
    import kv_lookup_responder_pkg::*;
#(
    parameter int KEY_SIZE = KV_KEY_SIZE,
    parameter int IDX_W    = KV_IDX_W,
    parameter int OP_W     = KV_OP_W
) (
    input  logic                  clk156,
    input  logic                  eth_rst,
    kv_lookup_responder_if.slave  bus
);
    localparam int CHUNKS = (KEY_SIZE + IDX_W - 1) / IDX_W;
    localparam int FOLD_W = CHUNKS * IDX_W;

    function automatic logic [IDX_W-1:0] hash_idx(input logic [KEY_SIZE-1:0] key);
        logic [FOLD_W-1:0] padded;
        logic [IDX_W-1:0]  h;
        padded = FOLD_W'(key);
        h      = '0;
        for (int i = 0; i < CHUNKS; i++) begin
            h = h ^ padded[i*IDX_W +: IDX_W];
        end
        return h;
    endfunction

    fsm_state_t           state;
    logic [IDX_W-1:0]     init_idx;
    logic                 init_done_q;

    logic                 s0_valid, s1_valid;
    logic [KEY_SIZE-1:0]  s0_key, s1_key;
    op_kind_t             s0_op, s1_op;
    logic [IDX_W-1:0]     s0_idx, s1_idx;

    logic                 out_valid_q;
    logic [OP_W-1:0]      out_flag_q;

    logic                 lw_valid;
    logic [IDX_W-1:0]     lw_idx;
    logic                 lw_v;
    logic [KEY_SIZE-1:0]  lw_key;

    logic [KEY_SIZE:0]    ram_rdata;
    logic                 ram_we;
    logic [IDX_W-1:0]     ram_waddr;
    logic [KEY_SIZE:0]    ram_wdata;

    logic                 fwd, cur_v, match, wr_req, s2_we, s2_wv;
    logic [KEY_SIZE-1:0]  cur_k;
    logic [3:0]           s2_flag;

    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            state       <= ST_INIT;
            init_idx    <= '0;
            init_done_q <= 1'b0;
        end else begin
            init_done_q <= (state == ST_RUN);
            case (state)
                ST_INIT: begin
                    init_idx <= init_idx + IDX_W'(1);
                    if (init_idx == '1) begin
                        state <= ST_RUN;
                    end
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            s0_valid    <= 1'b0;
            s1_valid    <= 1'b0;
            out_valid_q <= 1'b0;
            out_flag_q  <= '0;
            lw_valid    <= 1'b0;
        end else begin
            s0_valid    <= bus.in_valid;
            s1_valid    <= s0_valid;
            out_valid_q <= s1_valid;
            lw_valid    <= s2_we;
            if (s1_valid) begin
                out_flag_q <= OP_W'(s2_flag);
            end
        end
    end

    always_ff @(posedge clk156) begin
        s0_key <= bus.in_key;
        s0_idx <= hash_idx(bus.in_key);
        s0_op  <= (state == ST_INIT) ? OPC_REJECT : decode_op(bus.in_flag);
        s1_key <= s0_key;
        s1_idx <= s0_idx;
        s1_op  <= s0_op;
        lw_idx <= s1_idx;
        lw_v   <= s2_wv;
        lw_key <= s1_key;
    end

    // The RAM read for this request ran in the same cycle as the previous write;
    // if that write hit our index, its data replaces the stale read-first word.
    // NOTE: every always_comb output is given a default first so no path leaves it unassigned (no latch).
    always_comb begin
        fwd     = lw_valid && (lw_idx == s1_idx);
        cur_v   = fwd ? lw_v   : ram_rdata[KEY_SIZE];
        cur_k   = fwd ? lw_key : ram_rdata[KEY_SIZE-1:0];
        match   = cur_v && (cur_k == s1_key);
        s2_flag = 4'h0;
        wr_req  = 1'b0;
        s2_wv   = 1'b0;
        case (s1_op)
            OPC_LOOKUP: s2_flag = match ? KV_FLAG_HIT : 4'h0;
            OPC_INSERT: begin
                if (match) begin
                    s2_flag = KV_FLAG_HIT;
                end else if (!cur_v) begin
                    wr_req  = 1'b1;
                    s2_wv   = 1'b1;
                    s2_flag = KV_FLAG_WRITTEN;
                end else begin
                    s2_flag = KV_FLAG_ERR;
                end
            end
            OPC_DELETE: begin
                if (match) begin
                    wr_req  = 1'b1;
                    s2_flag = KV_FLAG_HIT | KV_FLAG_REMOVED;
                end
            end
            OPC_REJECT: s2_flag = KV_FLAG_ERR;
        endcase
        s2_we = s1_valid && wr_req;
    end

    always_comb begin
        if (state == ST_INIT) begin
            ram_we    = 1'b1;
            ram_waddr = init_idx;
            ram_wdata = '0;
        end else begin
            ram_we    = s2_we;
            ram_waddr = s1_idx;
            ram_wdata = {s2_wv, s1_key};
        end
    end

    kv_table_ram #(
        .WIDTH  (KEY_SIZE + 1),
        .ADDR_W (IDX_W)
    ) u_table (
        .clk156 (clk156),
        .we     (ram_we),
        .waddr  (ram_waddr),
        .wdata  (ram_wdata),
        .raddr  (s0_idx),
        .rdata  (ram_rdata)
    );

    assign bus.out_valid = out_valid_q;
    assign bus.out_flag  = out_flag_q;
    assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_kv_lookup_responder.sv
// Self-checking bench: directed steps plus a random op mix checked against a sequential table model.
module tb_kv_lookup_responder;
    localparam int KEY_SIZE = 96;
    localparam int IDX_W    = 10;
    localparam int OP_W     = 4;

    localparam logic [3:0] OP_LOOKUP = 4'h1;
    localparam logic [3:0] OP_INSERT = 4'h2;
    localparam logic [3:0] OP_DELETE = 4'h4;

    typedef struct {
        int         issue;
        logic [3:0] flag;
    } exp_t;

    logic clk156  = 1'b0;
    logic eth_rst = 1'b1;
    logic rst_seen = 1'b1;
    int   cycle_cnt = 0;
    int   test_cnt  = 0;
    int   fail_cnt  = 0;
    logic [OP_W-1:0] last_flag = '0;

    exp_t q[$];
    exp_t e;
    bit                  mv [int];
    logic [KEY_SIZE-1:0] mk [int];

    kv_lookup_responder_if #(.KEY_SIZE(KEY_SIZE), .OP_W(OP_W)) bus ();

    kv_lookup_responder #(
        .KEY_SIZE (KEY_SIZE),
        .IDX_W    (IDX_W),
        .OP_W     (OP_W)
    ) dut (
        .clk156  (clk156),
        .eth_rst (eth_rst),
        .bus     (bus)
    );

    always #5 clk156 = ~clk156;

    always @(posedge clk156) begin
        cycle_cnt <= cycle_cnt + 1;
        rst_seen  <= eth_rst;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        test_cnt++;
        assert (obs === expv) else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Hash bit j is the parity of every key bit whose position is j modulo IDX_W.
    function automatic int model_hash(input logic [KEY_SIZE-1:0] key);
        int h = 0;
        for (int i = 0; i < KEY_SIZE; i++) begin
            if (key[i]) h = h ^ (1 << (i % IDX_W));
        end
        return h;
    endfunction

    function automatic logic [3:0] model_apply(input logic [3:0] op, input logic [KEY_SIZE-1:0] key);
        int h;
        bit v, m;
        h = model_hash(key);
        v = mv.exists(h) && mv[h];
        m = v && (mk[h] == key);
        case (op)
            OP_LOOKUP: return m ? 4'h1 : 4'h0;
            OP_INSERT: begin
                if (m) return 4'h1;
                if (!v) begin
                    mv[h] = 1'b1;
                    mk[h] = key;
                    return 4'h2;
                end
                return 4'h8;
            end
            OP_DELETE: begin
                if (m) begin
                    mv[h] = 1'b0;
                    return 4'h5;
                end
                return 4'h0;
            end
            default: return 4'h8;
        endcase
    endfunction

    always @(negedge clk156) begin
        if (rst_seen) begin
            check("reset_out_valid", 128'(bus.out_valid), 128'(0));
            check("reset_out_flag", 128'(bus.out_flag), 128'(0));
            last_flag = '0;
        end else if (bus.out_valid) begin
            if (q.size() == 0) begin
                check("spurious_out_valid", 128'(bus.out_valid), 128'(0));
            end else begin
                e = q.pop_front();
                check("latency", 128'(cycle_cnt - e.issue), 128'(3));
                check("out_flag", 128'(bus.out_flag), 128'(e.flag));
            end
            last_flag = bus.out_flag;
        end else begin
            check("flag_hold", 128'(bus.out_flag), 128'(last_flag));
            if (q.size() != 0 && cycle_cnt >= q[0].issue + 3) begin
                check("resp_present", 128'(bus.out_valid), 128'(1));
                void'(q.pop_front());
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [KEY_SIZE-1:0] key, input logic [3:0] expf);
        bus.in_valid = 1'b1;
        bus.in_flag  = op;
        bus.in_key   = key;
        q.push_back('{issue: cycle_cnt, flag: expf});
    endtask

    task automatic dir(input logic [3:0] op, input logic [KEY_SIZE-1:0] key, input logic [3:0] lit);
        @(negedge clk156);
        void'(model_apply(op, key));
        send(op, key, lit);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk156);
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic release_and_wait(input bit busy_req, input logic [KEY_SIZE-1:0] key);
        int n;
        @(negedge clk156);
        eth_rst      = 1'b0;
        bus.in_valid = 1'b0;
        if (busy_req) send(OP_LOOKUP, key, 4'h8);
        n = 0;
        do begin
            @(negedge clk156);
            bus.in_valid = 1'b0;
            n++;
        end while (!bus.init_done && n < 4000);
        check("init_done_cycles", 128'(n), 128'(2**IDX_W + 1));
    endtask

    logic [KEY_SIZE-1:0] k1, k2, k3, k4, k5, k6, key;
    logic [KEY_SIZE-1:0] pool [32];
    logic [3:0]          op;
    int                  r;

    initial begin
        bus.in_valid = 1'b0;
        bus.in_flag  = '0;
        bus.in_key   = '0;
        k1 = 96'h0123_4567_89AB_CDEF_0123_45AB;
        k2 = k1 ^ 96'h1;
        k3 = k1 ^ 96'h401;
        k4 = k1 ^ 96'h2;
        k5 = k1 ^ 96'h4;
        k6 = k5 ^ 96'h401;

        repeat (16) @(negedge clk156);
        check("reset_init_done", 128'(bus.init_done), 128'(0));
        release_and_wait(1'b1, k1);

        dir(OP_INSERT, k1, 4'h2); idle(3);
        dir(OP_LOOKUP, k1, 4'h1);
        dir(OP_LOOKUP, k2, 4'h0); idle(3);
        dir(OP_INSERT, k3, 4'h8);
        dir(OP_LOOKUP, k1, 4'h1); idle(3);
        dir(OP_INSERT, k4, 4'h2);
        dir(OP_LOOKUP, k4, 4'h1);
        dir(OP_DELETE, k4, 4'h5);
        dir(OP_LOOKUP, k4, 4'h0); idle(3);
        dir(4'h3, k1, 4'h8);
        dir(OP_LOOKUP, k1, 4'h1);
        dir(4'h3, k5, 4'h8);
        dir(OP_LOOKUP, k5, 4'h0);
        dir(OP_INSERT, k1, 4'h1); idle(3);
        dir(OP_INSERT, k5, 4'h2);
        dir(OP_INSERT, k6, 4'h8);
        dir(OP_DELETE, k5, 4'h5);
        dir(OP_INSERT, k6, 4'h2);
        dir(OP_LOOKUP, k6, 4'h1); idle(4);

        // Three requests in flight when reset hits: none may be answered.
        dir(OP_LOOKUP, k1, 4'h1);
        dir(OP_LOOKUP, k6, 4'h1);
        @(negedge clk156);
        eth_rst      = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_flag  = OP_LOOKUP;
        bus.in_key   = k1;
        q.delete();
        mv.delete();
        mk.delete();
        idle(4);
        release_and_wait(1'b0, k1);
        dir(OP_LOOKUP, k1, 4'h0); idle(4);

        for (int i = 0; i < 32; i++) begin
            if (i < 16) pool[i] = {$urandom, $urandom, $urandom};
            else        pool[i] = pool[i-16] ^ (96'h401 << (i % 8));
        end
        for (int it = 0; it < 4000; it++) begin
            @(negedge clk156);
            if ($urandom_range(3) == 0) begin
                bus.in_valid = 1'b0;
            end else begin
                key = pool[$urandom_range(31)];
                r   = $urandom_range(99);
                if (r < 40)      op = OP_LOOKUP;
                else if (r < 70) op = OP_INSERT;
                else if (r < 95) op = OP_DELETE;
                else begin
                    do op = 4'($urandom_range(15));
                    while (op == OP_LOOKUP || op == OP_INSERT || op == OP_DELETE);
                end
                send(op, key, model_apply(op, key));
            end
        end
        idle(6);
        check("queue_drained", 128'(q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
        $finish;
    end

endmodule
